// File: rtl/bip_control_fsm.sv
// Run-control FSM and registered PC for the accumulator processor. It decodes the word returned
// by the synchronous instruction memory into datapath strobes, which are asserted only in EXEC.
module bip_control_fsm #(
  parameter int unsigned NBITS_ADDR = 11,
  parameter int unsigned NBITS_DATA = 16,
  parameter int unsigned OPCODE     = 5,
  parameter bit          SIGN_EXT   = 1'b1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_Start,
  input  logic                  i_StepMode,
  input  logic                  i_Step,
  input  logic                  i_AccZero,
  input  logic [NBITS_DATA-1:0] i_Instruction,
  output logic [NBITS_ADDR-1:0] o_Addr,
  output logic [NBITS_DATA-1:0] o_Operand,
  output logic [1:0]            o_SelA,
  output logic                  o_SelB,
  output logic                  o_WrAcc,
  output logic                  o_Op,
  output logic                  o_WrRam,
  output logic                  o_RdRam,
  output logic                  o_Busy,
  output logic                  o_Halted,
  output logic [31:0]           o_CycleCount
);

  localparam int unsigned OperandW = NBITS_DATA - OPCODE;

  localparam logic [OPCODE-1:0] OpHlt  = OPCODE'(0);
  localparam logic [OPCODE-1:0] OpSto  = OPCODE'(1);
  localparam logic [OPCODE-1:0] OpLd   = OPCODE'(2);
  localparam logic [OPCODE-1:0] OpLdi  = OPCODE'(3);
  localparam logic [OPCODE-1:0] OpAdd  = OPCODE'(4);
  localparam logic [OPCODE-1:0] OpAddi = OPCODE'(5);
  localparam logic [OPCODE-1:0] OpSub  = OPCODE'(6);
  localparam logic [OPCODE-1:0] OpSubi = OPCODE'(7);
  localparam logic [OPCODE-1:0] OpJmp  = OPCODE'(8);
  localparam logic [OPCODE-1:0] OpBeq  = OPCODE'(9);
  localparam logic [OPCODE-1:0] OpBne  = OPCODE'(10);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StStepWait,
    StHalt
  } state_e;

  state_e                state_q, state_d;
  logic [NBITS_ADDR-1:0] pc_q, pc_d;
  logic [31:0]           cycle_q, cycle_d;

  logic [OPCODE-1:0]     opcode;
  logic [OperandW-1:0]   field;
  logic [NBITS_DATA-1:0] operand;
  logic [NBITS_ADDR-1:0] target;
  logic [NBITS_ADDR-1:0] pc_inc;

  always_comb begin
    opcode = i_Instruction[NBITS_DATA-1 -: OPCODE];
    field  = i_Instruction[OperandW-1:0];
    if (SIGN_EXT) begin
      operand = {{OPCODE{field[OperandW-1]}}, field};
    end else begin
      operand = {{OPCODE{1'b0}}, field};
    end
    target = operand[NBITS_ADDR-1:0];
    pc_inc = pc_q + NBITS_ADDR'(1);
  end

  // Datapath strobes follow the opcode combinationally, gated to the EXEC cycle.
  always_comb begin
    o_SelA  = 2'b00;
    o_SelB  = 1'b0;
    o_WrAcc = 1'b0;
    o_Op    = 1'b0;
    o_WrRam = 1'b0;
    o_RdRam = 1'b0;
    if (state_q == StExec) begin
      unique case (opcode)
        OpSto: o_WrRam = 1'b1;
        OpLd: begin
          o_RdRam = 1'b1;
          o_WrAcc = 1'b1;
        end
        OpLdi: begin
          o_SelA  = 2'b01;
          o_WrAcc = 1'b1;
        end
        OpAdd, OpSub: begin
          o_RdRam = 1'b1;
          o_SelA  = 2'b10;
          o_WrAcc = 1'b1;
          o_Op    = (opcode == OpSub);
        end
        OpAddi, OpSubi: begin
          o_SelB  = 1'b1;
          o_SelA  = 2'b10;
          o_WrAcc = 1'b1;
          o_Op    = (opcode == OpSubi);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cycle_d = cycle_q;
    if ((state_q == StFetch || state_q == StExec) && cycle_q != '1) begin
      cycle_d = cycle_q + 32'd1;
    end
    case (state_q)
      StIdle: begin
        if (i_Start) state_d = StFetch;
      end
      StFetch: state_d = StExec;
      StExec: begin
        state_d = i_StepMode ? StStepWait : StFetch;
        case (opcode)
          OpHlt:   state_d = StHalt;
          OpJmp:   pc_d = target;
          OpBeq:   pc_d = i_AccZero ? target : pc_inc;
          OpBne:   pc_d = i_AccZero ? pc_inc : target;
          default: pc_d = pc_inc;
        endcase
      end
      StStepWait: begin
        if (i_Step || !i_StepMode) state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cycle_q <= cycle_d;
    end
  end

  assign o_Addr       = pc_q;
  assign o_Operand    = operand;
  assign o_Busy       = (state_q == StFetch) || (state_q == StExec) || (state_q == StStepWait);
  assign o_Halted     = (state_q == StHalt);
  assign o_CycleCount = cycle_q;

endmodule

// File: doc/bip_control_fsm.md
Name: bip_control_fsm

Overview:
- Clocked, parametrised control unit for the accumulator processor; replaces the combinational PC/decoder control.
- Owns a registered PC and a run-control FSM (IDLE/FETCH/EXEC/STEP_WAIT/HALT).
- Decodes the fetched instruction into datapath strobes, adds jump/conditional-branch/halt, and supports single-step mode for debug.
- Sits between instruction memory (synchronous read, 1-cycle latency) and the datapath (accumulator, ALU, data RAM).

Parameters:
- NBITS_ADDR, 11, PC / instruction-memory address width
- NBITS_DATA, 16, instruction and datapath word width
- OPCODE, 5, opcode field width (instruction bits [NBITS_DATA-1 : NBITS_DATA-OPCODE])
- SIGN_EXT, 1, 1 = operand field sign-extended to NBITS_DATA; 0 = zero-extended

Ports:
- i_clock  in  1  system clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_Start  in  1  leave IDLE and begin execution at PC=0
- i_StepMode  in  1  1 = pause in STEP_WAIT after each instruction
- i_Step  in  1  in STEP_WAIT, advance one instruction (level sampled per cycle)
- i_AccZero  in  1  accumulator == 0 flag from datapath
- i_Instruction  in  NBITS_DATA  instruction word, valid the cycle after o_Addr is presented
- o_Addr  out  NBITS_ADDR  instruction-memory address (= PC register)
- o_Operand  out  NBITS_DATA  extended operand field (bits [NBITS_DATA-OPCODE-1:0])
- o_SelA  out  2  accumulator source: 00 data RAM, 01 operand, 10 ALU
- o_SelB  out  1  ALU B source: 0 data RAM, 1 operand
- o_WrAcc  out  1  accumulator write strobe
- o_Op  out  1  ALU op: 0 add, 1 sub
- o_WrRam  out  1  data-RAM write strobe
- o_RdRam  out  1  data-RAM read strobe
- o_Busy  out  1  high in FETCH, EXEC, STEP_WAIT
- o_Halted  out  1  high in HALT
- o_CycleCount  out  32  cycles spent in FETCH/EXEC since reset; saturates at all-ones

Behaviour:
- Reset (i_reset=0 at clock edge):
  - Next state is IDLE; PC=0; o_CycleCount=0.
  - All strobes, o_SelA, o_SelB and o_Op are 0; o_Busy=0, o_Halted=0.
  - Reset wins over every other input, including mid-instruction.
- IDLE: o_Addr=0. i_Start=1 -> FETCH. Otherwise stay.
- FETCH (1 cycle): o_Addr=PC; no strobes -> EXEC.
- EXEC (1 cycle): decode i_Instruction.
  - Strobes, selects and op are combinational from the opcode, asserted only in EXEC; 0 in all other states.
  - Each instruction therefore takes 2 cycles.
- Opcode map (5-bit):
  - 00000 HLT: no strobes -> HALT; PC unchanged.
  - 00001 STO: WrRam.
  - 00010 LD: RdRam, SelA=00, WrAcc.
  - 00011 LDI: SelA=01, WrAcc.
  - 00100 ADD: RdRam, SelB=0, Op=0, SelA=10, WrAcc.
  - 00101 ADDI: SelB=1, Op=0, SelA=10, WrAcc.
  - 00110 SUB: as ADD with Op=1.
  - 00111 SUBI: as ADDI with Op=1.
  - 01000 JMP: PC <= operand[NBITS_ADDR-1:0].
  - 01001 BEQ: if i_AccZero, PC <= target; else PC+1.
  - 01010 BNE: if !i_AccZero, PC <= target; else PC+1.
  - Any other opcode: NOP, PC+1, no strobes.
- PC update in EXEC:
  - PC+1 for all non-branch, non-HLT opcodes.
  - Modulo 2^NBITS_ADDR: PC at all-ones wraps to 0, no flag.
  - Branch/jump targets are absolute and truncated to NBITS_ADDR.
  - i_AccZero is sampled in the EXEC cycle.
- After EXEC (non-HLT):
  - i_StepMode=0 -> FETCH.
  - i_StepMode=1 -> STEP_WAIT.
- STEP_WAIT:
  - Holds PC; no strobes.
  - i_Step=1 -> FETCH.
  - i_StepMode dropped to 0 -> FETCH (resume free-run).
- HALT: sticky until reset; i_Start, i_Step ignored; o_Addr holds the HLT address.
- i_Start is ignored outside IDLE.
- o_Operand is combinational from i_Instruction in every state (sign- or zero-extended per SIGN_EXT).
- o_CycleCount increments in FETCH and EXEC only; holds in IDLE, STEP_WAIT and HALT.

Test Plan:
- Reset/idle: hold i_reset=0 for 3 cycles, then release with i_Start=0 for 10 cycles -> o_Addr=0, all strobes 0, o_Busy=0, o_CycleCount=0.
- Program flow: program LDI 5; ADDI 3; STO 7; HLT with i_Start pulse ->
  - LDI EXEC: SelA=01, WrAcc=1, o_Operand=0x0005.
  - ADDI EXEC: SelA=10, SelB=1, Op=0, WrAcc=1.
  - STO EXEC: WrRam=1, o_Operand=0x0007.
  - Then o_Halted=1, o_Addr=3, o_CycleCount=8.
- Branches:
  - BEQ 0x040 with i_AccZero=1 -> next o_Addr=0x040.
  - BNE 0x040 with i_AccZero=1 -> PC+1.
  - JMP 0x7FF then NOP at 0x7FF -> next o_Addr=0x000 (wrap).
- Sign extension: LDI operand 0x7FF (11-bit) with SIGN_EXT=1 -> o_Operand=0xFFFF; with SIGN_EXT=0 -> 0x07FF.
- Step mode: i_StepMode=1 -> stays in STEP_WAIT (PC stable, strobes 0) for 20 cycles; one i_Step pulse -> exactly one FETCH+EXEC, then back to STEP_WAIT.
- Reset mid-operation: assert i_reset=0 during an EXEC of STO -> next cycle o_WrRam=0, PC=0, IDLE; a later i_Start restarts execution from address 0.
